// File: rtl/regime_pkg.sv
// Regime encodings shared with control_path, FSM state encoding and the preselect helper.
package regime_pkg;

    localparam logic [1:0] REG_OFF    = 2'd0;
    localparam logic [1:0] REG_ELIST  = 2'd1;
    localparam logic [1:0] REG_CNT    = 2'd2;
    localparam logic [1:0] REG_UPDATE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Preselect cycles ELIST -> CNT -> UPDATE -> ELIST and never yields OFF.
    function automatic logic [1:0] next_sel(input logic [1:0] s);
        case (s)
            REG_ELIST: return REG_CNT;
            REG_CNT:   return REG_UPDATE;
            default:   return REG_ELIST;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Single-button debouncer with a registered one-cycle press pulse on the rising stable level.
// With PANEL_INPUT_SYNC_EN defined the raw input first passes a two-flop synchronizer.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic raw_s;

`ifdef PANEL_INPUT_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    assign raw_s = sync_q[1];
`else
    assign raw_s = raw;
`endif

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (raw_s != stable_q) begin
            if (cnt_q == CntLast) begin
                stable_d = raw_s;
                press_d  = raw_s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    assign stable = stable_q;
    assign press  = press_q;

endmodule

// File: rtl/panel_input.sv
// Front-panel input stage: debounced buttons, regime preselect, on/start handshake to control_path.
// Build option PANEL_INPUT_SYNC_EN adds input synchronizers inside each button_debounce.
module panel_input
    import regime_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_go,
    input  logic       btn_start,
    input  logic       btn_cancel,
    input  logic [1:0] regime,
    output logic [1:0] on,
    output logic       start,
    output logic [1:0] sel,
    output logic       busy
);

    logic [3:0] btn_raw;
    logic [3:0] btn_stable;
    logic [3:0] btn_press;

    assign btn_raw = {btn_cancel, btn_start, btn_go, btn_mode};

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_mode (
        .clk(clk), .rst(rst), .raw(btn_raw[0]), .stable(btn_stable[0]), .press(btn_press[0])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_go (
        .clk(clk), .rst(rst), .raw(btn_raw[1]), .stable(btn_stable[1]), .press(btn_press[1])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_start (
        .clk(clk), .rst(rst), .raw(btn_raw[2]), .stable(btn_stable[2]), .press(btn_press[2])
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_cancel (
        .clk(clk), .rst(rst), .raw(btn_raw[3]), .stable(btn_stable[3]), .press(btn_press[3])
    );

    // Only the press pulses drive the FSM; stable levels are kept for debug visibility.
    logic unused_stable;
    assign unused_stable = ^btn_stable;

    logic mode_p, go_p, start_p, cancel_p;
    assign mode_p   = btn_press[0];
    assign go_p     = btn_press[1];
    assign start_p  = btn_press[2];
    assign cancel_p = btn_press[3];

    state_e     state_q;
    logic [1:0] on_q;
    logic       start_q;
    logic [1:0] sel_q;
    logic       busy_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            on_q    <= REG_OFF;
            start_q <= 1'b0;
            sel_q   <= REG_ELIST;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go_p && (regime == REG_OFF)) begin
                        on_q    <= sel_q;
                        state_q <= REQ;
                        busy_q  <= 1'b1;
                    end else if (mode_p) begin
                        sel_q <= next_sel(sel_q);
                    end
                end
                REQ: begin
                    // Acceptance outranks a cancel arriving in the same cycle.
                    if (regime != REG_OFF) begin
                        on_q    <= REG_OFF;
                        state_q <= RUN;
                    end else if (cancel_p) begin
                        on_q    <= REG_OFF;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (regime == REG_OFF) begin
                        start_q <= 1'b0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (cancel_p) begin
                        start_q <= 1'b0;
                    end else if (start_p) begin
                        start_q <= ~start_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    on_q    <= REG_OFF;
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign on    = on_q;
    assign start = start_q;
    assign sel   = sel_q;
    assign busy  = busy_q;

endmodule

// File: doc/panel_input.md
Name: panel_input

Overview:
- Upstream operator-input stage for control_path.
- Debounces four raw front-panel buttons and keeps a preselected regime.
- Issues the `on[1:0]` regime request with a hold-until-accepted handshake against control_path's `regime` output, and generates the `start` level that control_path samples in ELIST and CNT.
- Returns to idle when control_path falls back to OFF.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive identical samples needed before a button's stable level changes (min 2).
- CNT_W, 8: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low.
- btn_mode  in  1  raw button: cycle preselected regime.
- btn_go  in  1  raw button: request preselected regime.
- btn_start  in  1  raw button: toggle start level.
- btn_cancel  in  1  raw button: abort request / force start low.
- regime  in  2  current regime from control_path (0 OFF, 1 ELIST, 2 CNT, 3 UPDATE).
- on  out  2  regime request to control_path; 0 = no request.
- start  out  1  start level to control_path.
- sel  out  2  preselected regime, for display.
- busy  out  1  high when FSM is not IDLE.

Behaviour:
- Reset: synchronous, active-low. While rst==0 at a rising edge: on=0, start=0, sel=1, busy=0, FSM=IDLE, all debouncers stable=0 with counters=0.
- Debounce, per button:
  - Counter increments on each edge where raw != stable; cleared on any edge where raw == stable.
  - On the DEBOUNCE_CYCLES-th consecutive mismatching edge: stable <= raw, counter <= 0.
  - Press pulse is registered and high for exactly the first cycle in which stable is 1. Release produces no pulse.
  - Latency from raw rise (held steady) to press pulse: DEBOUNCE_CYCLES edges.
- FSM states: IDLE, REQ, RUN.
  - IDLE:
    - on=0, start=0.
    - mode press: sel 1→2→3→1.
    - go press while regime==0: latch on<=sel, go to REQ.
    - go press while regime!=0: ignored.
  - REQ:
    - on holds the latched value.
    - regime!=0: on<=0, go to RUN.
    - cancel press: on<=0, go to IDLE.
    - mode, go and start presses are ignored.
  - RUN:
    - on=0.
    - start press toggles start.
    - cancel press forces start<=0.
    - regime==0 (sampled at any edge): start<=0, go to IDLE.
- Simultaneous events:
  - IDLE, go and mode in the same cycle: go wins, uses the old sel, mode press is dropped.
  - RUN, start and cancel in the same cycle: start<=0.
  - REQ, cancel and regime!=0 in the same cycle: acceptance wins, go to RUN.
  - RUN, regime==0 and start press in the same cycle: go to IDLE, start=0.
- Outputs on, start, sel and busy are all registered; no combinational path from any input to any output.
- sel never takes the value 0.
- Reset mid-REQ or mid-RUN: synchronous clear to the reset values on the next edge. Partially debounced presses are discarded.

Optional Feature:
- Macro: PANEL_INPUT_SYNC_EN.
- Defined: each raw button passes through a two-flop synchronizer before its debouncer. Raw-to-press latency becomes DEBOUNCE_CYCLES+2 edges. Synchronizer flops reset to 0.
- Undefined: raw inputs feed the debouncers directly. Latency is DEBOUNCE_CYCLES.
- FSM behaviour is identical in both builds.

Decomposition:
- Shared package regime_pkg holds the regime encodings (REG_OFF=0, REG_ELIST=1, REG_CNT=2, REG_UPDATE=3) and the FSM state encoding (IDLE=0, REQ=1, RUN=2). control_path uses the same regime constants.
- One sub-module, button_debounce (params DEBOUNCE_CYCLES, CNT_W; ports clk, rst, raw, stable, press), instantiated four times.
- The optional synchronizer lives inside button_debounce.

Test Plan (DEBOUNCE_CYCLES=4, macro undefined):
- Reset, then btn_mode high for 3 edges and low → no press; sel stays 1. Held for 4 edges → press pulse after the 4th edge, 1 cycle wide; sel=2.
- sel=2, regime=0, go press → on=2, busy=1 next cycle. Drive regime=2 three cycles later → on=0 after that edge, state RUN.
- RUN with regime=2: start press → start=1; second start press → start=0; third → start=1; then cancel press → start=0.
- RUN with start=1: drive regime=0 → next edge start=0, busy=0, IDLE. A go press with regime=3 is then ignored (on stays 0).
- REQ with on=3: cancel press with regime=0 → on=0, IDLE. Repeat with cancel and regime=3 in the same cycle → RUN.
- Mid-RUN with start=1, sel=3: rst=0 for one edge → on=0, start=0, sel=1, busy=0. A button held across the reset needs 4 fresh edges to pulse.
